backdoor_override_ctrl: RTL and testbench
=========================================

Name: backdoor_override_ctrl

Overview:
- Parametrised, synthesisable backdoor override engine inserted between selected DUT nets and their loads.
- Gives the testbench a valid/ready command port to READ, DEPOSIT, FORCE (indefinite or timed) and RELEASE on NUM_CH channels.
- Every command returns exactly one response.
- Timed forces auto-release and flag expiry, so the env has no need for hierarchical force/release.

Parameters:
NUM_CH, 4, number of overridable channels (1..64)
DATA_W, 32, width of each channel
CNT_W, 16, width of the timed-force duration counter
CH_W, $clog2(NUM_CH) min 1, width of cmd_ch (derived, not overridden)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=READ 1=DEPOSIT 2=FORCE 3=RELEASE
cmd_ch  in  CH_W  target channel
cmd_data  in  DATA_W  override value (DEPOSIT/FORCE)
cmd_dur  in  CNT_W  FORCE duration in cycles; 0 = until RELEASE
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  DATA_W  hdl_in[cmd_ch] sampled at acceptance
rsp_err  out  1  command rejected, no side effects
hdl_in  in  NUM_CH*DATA_W  true DUT values, channel k at [k*DATA_W +: DATA_W]
hdl_out  out  NUM_CH*DATA_W  values driven to loads
forced  out  NUM_CH  per-channel FORCE active
evt_expire  out  NUM_CH  one-cycle pulse on timed auto-release

Behaviour:
- Reset state:
  - forced=0, evt_expire=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=1.
  - All counters are 0.
  - hdl_out=hdl_in.
- Reset mid-operation: pending response and all overrides are dropped at the reset edge. No expiry pulse is generated.
- Outstanding limit: one command at a time.
  - cmd_ready = !rsp_valid.
  - rsp_valid rises the cycle after acceptance and stays high, with stable data, until rsp_ready.
  - Throughput is one command per 2 cycles when rsp_ready is tied high.
- Output mux: hdl_out[k] is the override value when channel k is FORCE-active or DEPOSIT-active, otherwise hdl_in[k]. The mux is combinational; hdl_in to hdl_out has zero latency.
- Per-channel FSM states: IDLE, DEP (one cycle), HOLD (indefinite force), TIMED (counting force).
- Invalid channel: cmd_ch >= NUM_CH gives rsp_err=1, rsp_data=0, and no state change.
- Response data: rsp_data is always hdl_in[cmd_ch] at the acceptance cycle, i.e. the pre-override DUT value, for every valid op.
- READ: no state change; rsp_err=0.
- DEPOSIT:
  - On an IDLE channel: the channel goes to DEP for exactly the one cycle after acceptance (hdl_out=cmd_data), then returns to IDLE. forced stays 0.
  - On a HOLD or TIMED channel: rsp_err=1 and no effect.
- FORCE:
  - From the cycle after acceptance: hdl_out=cmd_data and forced=1.
  - cmd_dur=0 selects HOLD. cmd_dur=n selects TIMED: the counter loads n and forced stays high for exactly n cycles.
  - In the cycle after the last forced cycle: forced=0, hdl_out=hdl_in, and evt_expire pulses high for 1 cycle.
  - FORCE on an already-forced channel replaces the value and the mode, restarts the counter, and gives no expiry pulse.
- RELEASE:
  - From the cycle after acceptance: the channel is IDLE and forced=0. No evt_expire is generated.
  - RELEASE on an IDLE channel is a no-op with rsp_err=0.
- Simultaneous events on the same channel in the same cycle:
  - Timer expiry with an accepted FORCE: the command wins. The new force applies seamlessly with no gap cycle and no evt_expire.
  - Timer expiry with an accepted RELEASE: the channel releases and evt_expire stays 0.
  - Timer expiry with an accepted DEPOSIT: treated as forced, so rsp_err=1. Expiry proceeds normally.
- Channel independence: operations on one channel never alter another channel's state or counter.
- Counter width: counter is CNT_W bits. The maximum timed force is 2^CNT_W-1 cycles; there is no wrap.

Test Plan:
1. Reset/passthrough: rst 3 cycles, hdl_in ch2=0x1234_5678 -> hdl_out ch2=0x1234_5678, forced=0, cmd_ready=1, rsp_valid=0.
2. Timed force:
   - Stimulus: FORCE ch1 data=0xDEAD_BEEF dur=5, accepted at cycle t.
   - Required: hdl_out ch1=0xDEADBEEF and forced[1]=1 for cycles t+1..t+5. At t+6, forced[1]=0 and evt_expire[1]=1 for 1 cycle only. Response has rsp_err=0.
3. Indefinite force, then deposit/release:
   - Stimulus: FORCE ch0 0xA5 dur=0, hold 100 cycles.
   - Required: forced[0] stays 1. DEPOSIT ch0 0x11 returns rsp_err=1 with hdl_out unchanged. RELEASE ch0 gives hdl_out=hdl_in the cycle after acceptance, with no evt_expire.
4. Deposit/read: hdl_in ch3=0x42, DEPOSIT ch3 0x99 -> hdl_out ch3=0x99 for exactly 1 cycle, rsp_data=0x42. READ ch3 -> rsp_data=0x42, rsp_err=0.
5. Handshake/errors:
   - Stimulus: hold rsp_ready=0 for 4 cycles after a READ while keeping cmd_valid=1 with the next command.
   - Required: cmd_ready=0 and rsp_valid/rsp_data stable throughout; the next command is accepted only after the rsp handshake.
   - With NUM_CH=3, cmd_ch=3: rsp_err=1, rsp_data=0, no output change.
6. Collision/reset:
   - FORCE ch2 dur=3, then re-FORCE ch2 0x77 dur=2 accepted on the expiry cycle -> no gap, no evt_expire, 0x77 held 2 more cycles.
   - Separately: FORCE ch1 dur=10, assert rst at cycle 4 -> forced=0 and hdl_out=hdl_in at the reset edge, no pulse.

Source files
------------

// File: rtl/backdoor_override_ctrl.sv
// Backdoor override engine between DUT nets and their loads.
// One command at a time: read, deposit, force (held or timed), or release per channel.
module backdoor_override_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [CNT_W-1:0]         cmd_dur,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  input  logic [NUM_CH*DATA_W-1:0] hdl_in,
  output logic [NUM_CH*DATA_W-1:0] hdl_out,
  output logic [NUM_CH-1:0]        forced,
  output logic [NUM_CH-1:0]        evt_expire
);

  typedef enum logic [1:0] {ST_IDLE, ST_DEP, ST_HOLD, ST_TIMED} ch_state_e;
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_DEPOSIT = 2'd1,
    OP_FORCE   = 2'd2,
    OP_RELEASE = 2'd3
  } op_e;

  ch_state_e         state_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [DATA_W-1:0] val_q   [NUM_CH];
  logic [NUM_CH-1:0] expire_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_data_q;

  op_e               op;
  logic              accept;
  logic              ch_ok;
  logic              sel_forced;
  logic              cmd_err;
  logic [DATA_W-1:0] sel_in;
  logic [NUM_CH-1:0] ch_hit;

  // Channel decode by compare rather than indexing, so out-of-range cmd_ch selects nothing.
  always_comb begin
    op         = op_e'(cmd_op);
    accept     = cmd_valid && !rsp_valid_q;
    ch_ok      = 1'b0;
    sel_in     = '0;
    sel_forced = 1'b0;
    ch_hit     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (cmd_ch == CH_W'(k)) begin
        ch_ok      = 1'b1;
        sel_in     = hdl_in[k*DATA_W +: DATA_W];
        sel_forced = (state_q[k] == ST_HOLD) || (state_q[k] == ST_TIMED);
        ch_hit[k]  = accept;
      end
    end
    cmd_err = !ch_ok || ((op == OP_DEPOSIT) && sel_forced);
    ch_hit  = ch_hit & {NUM_CH{!cmd_err}};
  end

  always_comb begin
    forced  = '0;
    hdl_out = hdl_in;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      forced[k] = (state_q[k] == ST_HOLD) || (state_q[k] == ST_TIMED);
      if (state_q[k] != ST_IDLE) hdl_out[k*DATA_W +: DATA_W] = val_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      expire_q    <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
        val_q[k]   <= '0;
      end
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= sel_in;
        rsp_err_q   <= cmd_err;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        expire_q[k] <= 1'b0;
        case (state_q[k])
          ST_DEP:   state_q[k] <= ST_IDLE;
          ST_TIMED: begin
            if (cnt_q[k] == CNT_W'(1)) begin
              state_q[k]  <= ST_IDLE;
              cnt_q[k]    <= '0;
              expire_q[k] <= 1'b1;
            end else begin
              cnt_q[k] <= cnt_q[k] - CNT_W'(1);
            end
          end
          default: ;
        endcase
        // An accepted command is assigned last so it overrides a same-cycle expiry.
        if (ch_hit[k]) begin
          case (op)
            OP_DEPOSIT: begin
              state_q[k] <= ST_DEP;
              val_q[k]   <= cmd_data;
            end
            OP_FORCE: begin
              val_q[k]    <= cmd_data;
              cnt_q[k]    <= cmd_dur;
              state_q[k]  <= (cmd_dur == '0) ? ST_HOLD : ST_TIMED;
              expire_q[k] <= 1'b0;
            end
            OP_RELEASE: begin
              state_q[k]  <= ST_IDLE;
              cnt_q[k]    <= '0;
              expire_q[k] <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign cmd_ready  = !rsp_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign evt_expire = expire_q;

endmodule

// File: tb/tb_backdoor_override_ctrl.sv
// Bench for backdoor_override_ctrl: directed scenarios plus a randomized run
// checked against a timestamp-based model of force/deposit windows.
module tb_backdoor_override_ctrl;

  localparam longint NONE = -1;
  localparam longint BIG  = 64'h3fff_ffff_ffff_ffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [1:0]   cmd_ch;
  logic [31:0]  cmd_data;
  logic [7:0]   cmd_dur;
  logic         rsp_valid, rsp_ready;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic [127:0] hdl_in, hdl_out;
  logic [3:0]   forced, evt_expire;

  logic         c3_valid, c3_ready;
  logic [1:0]   c3_op;
  logic [1:0]   c3_ch;
  logic [31:0]  c3_data;
  logic [15:0]  c3_dur;
  logic         c3_rsp_valid, c3_rsp_ready;
  logic [31:0]  c3_rsp_data;
  logic         c3_rsp_err;
  logic [95:0]  c3_hdl_in, c3_hdl_out;
  logic [2:0]   c3_forced, c3_expire;

  backdoor_override_ctrl #(.NUM_CH(4), .DATA_W(32), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_dur(cmd_dur),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .hdl_in(hdl_in), .hdl_out(hdl_out), .forced(forced), .evt_expire(evt_expire)
  );

  backdoor_override_ctrl #(.NUM_CH(3), .DATA_W(32), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_ch(c3_ch), .cmd_data(c3_data), .cmd_dur(c3_dur),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
    .rsp_err(c3_rsp_err), .hdl_in(c3_hdl_in), .hdl_out(c3_hdl_out),
    .forced(c3_forced), .evt_expire(c3_expire)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_err = 0;
  longint cyc   = 0;

  // Model: channel k is forced in cycles f_from..f_until, deposits show in cycle dep_at,
  // and an expiry pulse is due in cycle exp_at.
  longint      f_from [4];
  longint      f_until[4];
  longint      exp_at [4];
  longint      dep_at [4];
  logic [31:0] m_val  [4];
  bit          m_pend;
  logic [31:0] m_data;
  bit          m_rerr;

  function automatic logic [31:0] out_ch(input int k);
    return hdl_out[k*32 +: 32];
  endfunction

  function automatic logic [31:0] in_ch(input int k);
    return hdl_in[k*32 +: 32];
  endfunction

  task automatic set_in(input int k, input logic [31:0] v);
    hdl_in[k*32 +: 32] = v;
  endtask

  function automatic bit m_forced(input int k, input longint c);
    return (c >= f_from[k]) && (c <= f_until[k]);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      f_from[k]  = 0;
      f_until[k] = NONE;
      exp_at[k]  = NONE;
      dep_at[k]  = NONE;
      m_val[k]   = '0;
    end
    m_pend = 0;
    m_data = '0;
    m_rerr = 0;
  endtask

  task automatic model_edge();
    longint t;
    bit     acc;
    bit     frc;
    int     ch;
    t = cyc;
    cyc++;
    if (rst) begin
      model_clear();
      return;
    end
    acc = cmd_valid && !m_pend;
    if (m_pend && rsp_ready) m_pend = 0;
    if (acc) begin
      ch     = int'(cmd_ch);
      frc    = m_forced(ch, t);
      m_pend = 1;
      m_data = hdl_in[ch*32 +: 32];
      m_rerr = (cmd_op == 2'd1) && frc;
      case (cmd_op)
        2'd1: if (!frc) begin
          m_val[ch]  = cmd_data;
          dep_at[ch] = t + 1;
        end
        2'd2: begin
          m_val[ch]   = cmd_data;
          f_from[ch]  = t + 1;
          f_until[ch] = (cmd_dur == 0) ? BIG : t + longint'(cmd_dur);
          exp_at[ch]  = (cmd_dur == 0) ? NONE : t + longint'(cmd_dur) + 1;
        end
        2'd3: begin
          f_until[ch] = t;
          exp_at[ch]  = NONE;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int ch, input logic [31:0] data,
                       input logic [7:0] dur);
    bit rdy;
    bit done;
    done      = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = 2'(ch);
    cmd_data  = data;
    cmd_dur   = dur;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) done = 1;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL issue_accept: op=%0d ch=%0d accepted=0 required=1", op, ch);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hdl_in = {$urandom, $urandom, $urandom, $urandom};
    set_in(2, 32'h1234_5678);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (out_ch(2) !== 32'h1234_5678) begin
      n_err++; $display("FAIL reset_passthru: got %h required 12345678", out_ch(2));
    end
    n_cmp++;
    if (forced !== 4'b0 || evt_expire !== 4'b0) begin
      n_err++; $display("FAIL reset_flags: forced=%b expire=%b required 0000/0000", forced, evt_expire);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_handshake: ready=%b rvalid=%b rdata=%h rerr=%b required 1/0/0/0",
               cmd_ready, rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_timed_force();
    rsp_ready = 1'b1;
    set_in(1, 32'h0BAD_F00D);
    issue(2'd2, 1, 32'hDEAD_BEEF, 8'd5);
    for (int i = 1; i <= 5; i++) begin
      n_cmp++;
      if (out_ch(1) !== 32'hDEAD_BEEF || forced[1] !== 1'b1 || evt_expire[1] !== 1'b0) begin
        n_err++;
        $display("FAIL timed_active: t+%0d out=%h forced=%b expire=%b required deadbeef/1/0",
                 i, out_ch(1), forced[1], evt_expire[1]);
      end
      if (i == 1) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0BAD_F00D) begin
          n_err++;
          $display("FAIL timed_rsp: valid=%b err=%b data=%h required 1/0/0badf00d",
                   rsp_valid, rsp_err, rsp_data);
        end
      end
      tick();
    end
    n_cmp++;
    if (forced[1] !== 1'b0 || evt_expire[1] !== 1'b1 || out_ch(1) !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL timed_expire: forced=%b expire=%b out=%h required 0/1/0badf00d",
               forced[1], evt_expire[1], out_ch(1));
    end
    tick();
    n_cmp++;
    if (evt_expire !== 4'b0) begin
      n_err++; $display("FAIL timed_pulse_width: expire=%b required 0000", evt_expire);
    end
  endtask

  task automatic test_hold_dep_release();
    rsp_ready = 1'b1;
    set_in(0, 32'h0000_1111);
    issue(2'd2, 0, 32'h0000_00A5, 8'd0);
    for (int i = 0; i < 100; i++) begin
      n_cmp++;
      if (forced[0] !== 1'b1 || out_ch(0) !== 32'hA5 || evt_expire !== 4'b0) begin
        n_err++;
        $display("FAIL hold_active: i=%0d forced=%b out=%h expire=%b required 1/a5/0",
                 i, forced[0], out_ch(0), evt_expire);
      end
      tick();
    end
    issue(2'd1, 0, 32'h11, 8'd0);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h1111 || out_ch(0) !== 32'hA5) begin
      n_err++;
      $display("FAIL deposit_on_forced: valid=%b err=%b data=%h out=%h required 1/1/1111/a5",
               rsp_valid, rsp_err, rsp_data, out_ch(0));
    end
    tick();
    n_cmp++;
    if (out_ch(0) !== 32'hA5) begin
      n_err++; $display("FAIL deposit_no_effect: out=%h required a5", out_ch(0));
    end
    issue(2'd3, 0, 32'h0, 8'd0);
    n_cmp++;
    if (out_ch(0) !== 32'h1111 || forced[0] !== 1'b0 || evt_expire !== 4'b0 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL release: out=%h forced=%b expire=%b err=%b required 1111/0/0/0",
               out_ch(0), forced[0], evt_expire, rsp_err);
    end
    tick();
    n_cmp++;
    if (evt_expire !== 4'b0) begin
      n_err++; $display("FAIL release_no_pulse: expire=%b required 0000", evt_expire);
    end
  endtask

  task automatic test_deposit_read();
    rsp_ready = 1'b1;
    set_in(3, 32'h42);
    issue(2'd1, 3, 32'h99, 8'd0);
    n_cmp++;
    if (out_ch(3) !== 32'h99 || forced[3] !== 1'b0 || rsp_data !== 32'h42 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL deposit: out=%h forced=%b data=%h err=%b required 99/0/42/0",
               out_ch(3), forced[3], rsp_data, rsp_err);
    end
    tick();
    n_cmp++;
    if (out_ch(3) !== 32'h42) begin
      n_err++; $display("FAIL deposit_one_cycle: out=%h required 42", out_ch(3));
    end
    issue(2'd0, 3, 32'h0, 8'd0);
    n_cmp++;
    if (rsp_data !== 32'h42 || rsp_err !== 1'b0 || out_ch(3) !== 32'h42) begin
      n_err++;
      $display("FAIL read: data=%h err=%b out=%h required 42/0/42", rsp_data, rsp_err, out_ch(3));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    set_in(2, 32'hCAFE_0002);
    issue(2'd0, 2, 32'h0, 8'd0);
    set_in(2, 32'h0);
    set_in(1, 32'h5151_5151);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_ch    = 2'd1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rsp_ready = 1'b1;
      n_cmp++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hCAFE_0002 || rsp_err !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: i=%0d ready=%b valid=%b data=%h required 0/1/cafe0002",
                 i, cmd_ready, rsp_valid, rsp_data);
      end
      tick();
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_release: valid=%b ready=%b required 0/1", rsp_valid, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h5151_5151) begin
      n_err++; $display("FAIL next_cmd: valid=%b data=%h required 1/51515151", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_invalid_ch();
    c3_hdl_in    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    c3_rsp_ready = 1'b1;
    c3_valid     = 1'b1;
    c3_op        = 2'd2;
    c3_ch        = 2'd3;
    c3_data      = 32'hFFFF_FFFF;
    c3_dur       = 16'd0;
    tick();
    c3_valid = 1'b0;
    n_cmp++;
    if (c3_rsp_valid !== 1'b1 || c3_rsp_err !== 1'b1 || c3_rsp_data !== 32'h0) begin
      n_err++;
      $display("FAIL invalid_ch_rsp: valid=%b err=%b data=%h required 1/1/0",
               c3_rsp_valid, c3_rsp_err, c3_rsp_data);
    end
    n_cmp++;
    if (c3_forced !== 3'b0 || c3_hdl_out !== c3_hdl_in) begin
      n_err++;
      $display("FAIL invalid_ch_effect: forced=%b out=%h required 000/%h", c3_forced, c3_hdl_out, c3_hdl_in);
    end
    tick();
    c3_valid = 1'b1;
    c3_ch    = 2'd2;
    c3_data  = 32'h0000_ABCD;
    tick();
    c3_valid = 1'b0;
    n_cmp++;
    if (c3_rsp_err !== 1'b0 || c3_rsp_data !== 32'h3333_3333 || c3_forced !== 3'b100 ||
        c3_hdl_out[64 +: 32] !== 32'hABCD) begin
      n_err++;
      $display("FAIL top_ch_force: err=%b data=%h forced=%b out=%h required 0/33333333/100/abcd",
               c3_rsp_err, c3_rsp_data, c3_forced, c3_hdl_out[64 +: 32]);
    end
    tick();
  endtask

  task automatic test_collision();
    rsp_ready = 1'b1;
    issue(2'd2, 2, 32'h55, 8'd3);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_ch    = 2'd2;
    cmd_data  = 32'h77;
    cmd_dur   = 8'd2;
    n_cmp++;
    if (cmd_ready !== 1'b1 || forced[2] !== 1'b1 || out_ch(2) !== 32'h55) begin
      n_err++;
      $display("FAIL collide_last: ready=%b forced=%b out=%h required 1/1/55", cmd_ready, forced[2], out_ch(2));
    end
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (forced[2] !== 1'b1 || out_ch(2) !== 32'h77 || evt_expire !== 4'b0) begin
        n_err++;
        $display("FAIL collide_refresh: i=%0d forced=%b out=%h expire=%b required 1/77/0",
                 i, forced[2], out_ch(2), evt_expire);
      end
      tick();
    end
    n_cmp++;
    if (forced[2] !== 1'b0 || evt_expire[2] !== 1'b1) begin
      n_err++; $display("FAIL collide_expire: forced=%b expire=%b required 0/1", forced[2], evt_expire[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_in(1, 32'h7777_0001);
    issue(2'd2, 1, 32'hF00D, 8'd10);
    tick();
    tick();
    n_cmp++;
    if (forced[1] !== 1'b1 || rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset: forced=%b valid=%b required 1/1", forced[1], rsp_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (forced !== 4'b0 || out_ch(1) !== 32'h7777_0001 || evt_expire !== 4'b0 ||
        rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: forced=%b out=%h expire=%b valid=%b ready=%b required 0/77770001/0/0/1",
               forced, out_ch(1), evt_expire, rsp_valid, cmd_ready);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (evt_expire !== 4'b0 || forced !== 4'b0) begin
        n_err++;
        $display("FAIL post_reset_quiet: i=%0d expire=%b forced=%b required 0/0", i, evt_expire, forced);
      end
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_max_duration();
    int cnt;
    rsp_ready = 1'b1;
    issue(2'd2, 3, 32'h5A5A_5A5A, 8'd255);
    cnt = 0;
    while (forced[3] === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != 255 || evt_expire[3] !== 1'b1) begin
      n_err++; $display("FAIL max_duration: cycles=%0d expire=%b required 255/1", cnt, evt_expire[3]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] e_out;
    logic [3:0]   e_f, e_x;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_ch    = 2'($urandom_range(0, 3));
      cmd_data  = $urandom;
      cmd_dur   = 8'($urandom_range(0, 6));
      rsp_ready = ($urandom_range(0, 3) != 0);
      hdl_in    = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int k = 0; k < 4; k++) begin
        e_f[k] = m_forced(k, cyc);
        e_x[k] = (exp_at[k] == cyc);
        e_out[k*32 +: 32] = (e_f[k] || dep_at[k] == cyc) ? m_val[k] : hdl_in[k*32 +: 32];
      end
      n_cmp++;
      if (hdl_out !== e_out) begin
        n_err++; $display("FAIL rand_out: cyc=%0d got %h required %h", cyc, hdl_out, e_out);
      end
      n_cmp++;
      if (forced !== e_f || evt_expire !== e_x) begin
        n_err++;
        $display("FAIL rand_flags: cyc=%0d forced=%b expire=%b required %b/%b", cyc, forced, evt_expire, e_f, e_x);
      end
      n_cmp++;
      if (cmd_ready !== !m_pend || rsp_valid !== m_pend) begin
        n_err++;
        $display("FAIL rand_hs: cyc=%0d ready=%b valid=%b required %b/%b", cyc, cmd_ready, rsp_valid, !m_pend, m_pend);
      end
      if (m_pend) begin
        n_cmp++;
        if (rsp_data !== m_data || rsp_err !== m_rerr) begin
          n_err++;
          $display("FAIL rand_rsp: cyc=%0d data=%h err=%b required %h/%b", cyc, rsp_data, rsp_err, m_data, m_rerr);
        end
      end
      tick();
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_ch       = 2'd0;
    cmd_data     = '0;
    cmd_dur      = '0;
    rsp_ready    = 1'b1;
    hdl_in       = '0;
    c3_valid     = 1'b0;
    c3_op        = 2'd0;
    c3_ch        = 2'd0;
    c3_data      = '0;
    c3_dur       = '0;
    c3_rsp_ready = 1'b1;
    c3_hdl_in    = '0;
    model_clear();
    test_reset();
    test_timed_force();
    test_hold_dep_release();
    test_deposit_read();
    test_back_to_back();
    test_invalid_ch();
    test_collision();
    test_reset_mid();
    test_max_duration();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
